router_input_port: RTL and testbench

Input-side companion of the router's per-output 4/5-way arbiters. It buffers incoming flits from one link, computes the XY route of each packet from its head flit, and drives a one-hot request to the output arbiters. The request is held stable for the whole packet, as the arbiters require. When a grant arrives it forwards flits and produces the `forwarding_head`/`forwarding_tail` strobes the arbiters use to lock grants and rotate priority. One instance per router input port (N, S, W, E, Local).

---
 rtl/router_pkg.sv | 54 +++++
 rtl/router_input_fifo.sv | 64 ++++++
 rtl/router_input_port.sv | 121 ++++++++++++
 tb/tb_router_input_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types, flit field offsets and the XY routing function for the router input side.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: not applicable.
package router_pkg;

    localparam int FLIT_SIZE_DEF = 34;
    localparam int NUM_DIRS      = 5;

    // Output directions; the value is also the bit index in a one-hot request.
    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_S = 3'd1,
        DIR_W = 3'd2,
        DIR_E = 3'd3,
        DIR_L = 3'd4
    } noc_dir_t;

    // Input port packet state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } port_state_t;

    // Field positions given as distance below the flit width, so any FlitSize works.
    localparam int HEAD_OFS  = 1;
    localparam int TAIL_OFS  = 2;
    localparam int SRC_Y_OFS = 3;
    localparam int SRC_X_OFS = 6;
    localparam int DST_Y_OFS = 9;
    localparam int DST_X_OFS = 12;

    // Dimension-ordered route: resolve X first, then Y, else deliver locally.
    function automatic logic [NUM_DIRS-1:0] xy_route(
        input logic [2:0] dst_x,
        input logic [2:0] dst_y,
        input logic [2:0] pos_x,
        input logic [2:0] pos_y
    );
        noc_dir_t dir;
        if (dst_x > pos_x) begin
            dir = DIR_E;
        end else if (dst_x < pos_x) begin
            dir = DIR_W;
        end else if (dst_y > pos_y) begin
            dir = DIR_S;
        end else if (dst_y < pos_y) begin
            dir = DIR_N;
        end else begin
            dir = DIR_L;
        end
        return NUM_DIRS'(1) << dir;
    endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Register-based circular flit buffer with full/empty/count status.
// Latency: a flit written at edge t is readable at the head from cycle t+1; no bypass.
// Backpressure: pushes while full and pops while empty are ignored; caller gates on status.
module router_input_fifo
    import router_pkg::*;
#(
    parameter int Depth    = 4,
    parameter int FlitSize = FLIT_SIZE_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [FlitSize-1:0]         wr_dat_i,
    input  logic                        pop_i,
    output logic [FlitSize-1:0]         rd_dat_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(Depth):0]      count_o
);

    localparam int PTR_W = $clog2(Depth);
    localparam int CNT_W = PTR_W + 1;

    logic [FlitSize-1:0] mem_q [Depth];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                do_push, do_pop;

    assign full_o   = (count_q == CNT_W'(Depth));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage and pointers; reset clears storage so the head reads zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_input_port.sv
// Router input port: buffers link flits, XY-routes each packet and requests/forwards to outputs.
// Latency: flit accepted at edge t drives data_out/request in cycle t+1; 1 flit/cycle sustained.
// Backpressure: stop_out while the FIFO is full; forwarding waits on grant (head) and out_ready.
module router_input_port
    import router_pkg::*;
#(
    parameter int FlitSize = FLIT_SIZE_DEF,
    parameter int Depth    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          position_x,
    input  logic [2:0]          position_y,
    input  logic [FlitSize-1:0] data_in,
    input  logic                data_void_in,
    output logic                stop_out,
    output logic [4:0]          request,
    input  logic [4:0]          grant,
    input  logic [4:0]          out_ready,
    output logic [FlitSize-1:0] data_out,
    output logic                forwarding,
    output logic                forwarding_head,
    output logic                forwarding_tail,
    output logic                drop_pulse
);

    localparam int CNT_W = $clog2(Depth) + 1;

    logic                fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    port_state_t         state_q;
    logic [NUM_DIRS-1:0] route_q;
    logic                head_bit, tail_bit;
    logic [2:0]          dst_x, dst_y;
    logic [NUM_DIRS-1:0] head_route;

    // Full is taken from the registered count so stop_out never depends on this cycle's pop.
    assign stop_out  = (fifo_count == CNT_W'(Depth));
    assign fifo_push = !data_void_in && !stop_out;
    assign fifo_pop  = forwarding || drop_pulse;

    router_input_fifo #(
        .Depth    (Depth),
        .FlitSize (FlitSize)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (fifo_push),
        .wr_dat_i (data_in),
        .pop_i    (fifo_pop),
        .rd_dat_o (data_out),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign head_bit   = data_out[FlitSize-HEAD_OFS];
    assign tail_bit   = data_out[FlitSize-TAIL_OFS];
    assign dst_y      = data_out[FlitSize-DST_Y_OFS -: 3];
    assign dst_x      = data_out[FlitSize-DST_X_OFS -: 3];
    assign head_route = xy_route(dst_x, dst_y, position_x, position_y);

    // Request/forward decision; in PKT the arbiter is locked so only out_ready matters.
    always_comb begin
        request    = '0;
        forwarding = 1'b0;
        drop_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_bit) begin
                        request    = head_route;
                        forwarding = |(head_route & grant & out_ready);
                    end else begin
                        drop_pulse = 1'b1;
                    end
                end
            end
            ST_PKT: begin
                request    = route_q;
                forwarding = !fifo_empty && |(route_q & out_ready);
            end
            default: ;
        endcase
    end

    // A head-flagged flit inside a packet is just payload, so only IDLE forwards count as heads.
    assign forwarding_head = forwarding && (state_q == ST_IDLE);
    assign forwarding_tail = forwarding && tail_bit;

    // Packet FSM: latch the route when a multi-flit head leaves, release on the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (forwarding && !tail_bit) begin
                        state_q <= ST_PKT;
                        route_q <= request;
                    end
                end
                ST_PKT: begin
                    if (forwarding && tail_bit) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_request_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(request));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
    a_no_fwd_when_empty: assert property (@(posedge clk) disable iff (rst) !(forwarding && fifo_empty));
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port: directed packets, expected flits queued at issue time.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: exercises grant withholding, out_ready stalls, FIFO full and reset mid-packet.
module tb_router_input_port;

    localparam int FS  = 34;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    position_x, position_y;
    logic [FS-1:0] data_in;
    logic          data_void_in;
    logic          stop_out;
    logic [4:0]    request;
    logic [4:0]    grant;
    logic [4:0]    out_ready;
    logic [FS-1:0] data_out;
    logic          forwarding, forwarding_head, forwarding_tail, drop_pulse;

    always #5 clk = ~clk;

    router_input_port #(.FlitSize(FS), .Depth(DEP)) dut (
        .clk             (clk),
        .rst             (rst),
        .position_x      (position_x),
        .position_y      (position_y),
        .data_in         (data_in),
        .data_void_in    (data_void_in),
        .stop_out        (stop_out),
        .request         (request),
        .grant           (grant),
        .out_ready       (out_ready),
        .data_out        (data_out),
        .forwarding      (forwarding),
        .forwarding_head (forwarding_head),
        .forwarding_tail (forwarding_tail),
        .drop_pulse      (drop_pulse)
    );

    typedef struct {
        logic [FS-1:0] dat;
        logic [4:0]    req;
        logic          fh;
        logic          ft;
    } exp_t;

    exp_t          exp_q[$];
    logic [FS-1:0] drop_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [FS-1:0] mk(input logic h, input logic t, input logic [2:0] dx,
                                         input logic [2:0] dy, input logic [19:0] pl);
        return {h, t, 3'd1, 3'd1, dy, dx, pl};
    endfunction

    task automatic expect_fwd(input logic [FS-1:0] f, input logic [4:0] r, input logic fh,
                              input logic ft);
        exp_t e;
        e.dat = f; e.req = r; e.fh = fh; e.ft = ft;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [FS-1:0] f);
        tick();
        data_in      = f;
        data_void_in = 1'b0;
    endtask

    task automatic idle();
        tick();
        data_void_in = 1'b1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: every forwarded or dropped flit is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && forwarding) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_forward actual=%0h required=none", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("fwd_data", data_out, e.dat);
                chk("fwd_request", request, e.req);
                chk("fwd_head", forwarding_head, e.fh);
                chk("fwd_tail", forwarding_tail, e.ft);
            end
        end
        if (!rst && drop_pulse) begin
            if (drop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_drop actual=%0h required=none", data_out);
            end else begin
                chk("drop_data", data_out, drop_q.pop_front());
            end
        end
    end

    initial begin
        logic [FS-1:0] h, b, b2, t, x;

        rst = 1'b1; data_void_in = 1'b1; data_in = '0;
        grant = '0; out_ready = '0; position_x = 3'd2; position_y = 3'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        at_neg();
        chk("rst_stop_out", stop_out, 0);
        chk("rst_request", request, 0);
        chk("rst_forwarding", {forwarding, forwarding_head, forwarding_tail}, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_data_out", data_out, 0);

        // Single-flit packet to (5,1) from (2,2): east
        h = mk(1, 1, 3'd5, 3'd1, 20'h00011);
        expect_fwd(h, 5'b01000, 1, 1);
        grant = 5'b01000; out_ready = 5'b11111;
        drive(h);
        at_neg(); chk("t1_no_bypass", forwarding, 0);
        idle(); at_neg(); chk("t1_request", request, 5'b01000);
        idle(); at_neg(); chk("t1_back_idle", request, 0);

        // 3-flit packet to (2,0): north, grant withheld 4 cycles
        grant = '0;
        h = mk(1, 0, 3'd2, 3'd0, 20'h00021);
        b = mk(0, 0, 3'd7, 3'd7, 20'h00022);
        t = mk(0, 1, 3'd0, 3'd0, 20'h00023);
        expect_fwd(h, 5'b00001, 1, 0);
        expect_fwd(b, 5'b00001, 0, 0);
        expect_fwd(t, 5'b00001, 0, 1);
        drive(h); drive(b); drive(t);
        for (int i = 0; i < 4; i++) begin
            idle(); at_neg();
            chk("t2_req_hold", request, 5'b00001);
            chk("t2_no_fwd", forwarding, 0);
            chk("t2_not_full", stop_out, 0);
        end
        tick(); grant = 5'b00001; at_neg(); chk("t2_head_fwd", forwarding_head, 1);
        tick(); grant = '0;       at_neg(); chk("t2_body_fwd_no_grant", forwarding, 1);
        tick();                   at_neg(); chk("t2_tail_fwd", forwarding_tail, 1);
        tick();                   at_neg(); chk("t2_req_drop", request, 0);

        // Packet runs the FIFO empty mid-flight
        grant = 5'b00001;
        h = mk(1, 0, 3'd2, 3'd0, 20'h00031);
        b = mk(0, 0, 3'd0, 3'd0, 20'h00032);
        t = mk(0, 1, 3'd0, 3'd0, 20'h00033);
        expect_fwd(h, 5'b00001, 1, 0);
        expect_fwd(b, 5'b00001, 0, 0);
        expect_fwd(t, 5'b00001, 0, 1);
        drive(h);
        idle(); at_neg(); chk("t3_head_fwd", forwarding_head, 1);
        tick(); grant = '0; at_neg();
        chk("t3_req_empty", request, 5'b00001); chk("t3_no_fwd_empty", forwarding, 0);
        drive(b); at_neg();
        chk("t3_req_push", request, 5'b00001); chk("t3_no_fwd_push", forwarding, 0);
        idle(); at_neg();
        chk("t3_body_fwd", forwarding, 1); chk("t3_body_req", request, 5'b00001);
        tick(); at_neg();
        chk("t3_req_empty2", request, 5'b00001); chk("t3_no_fwd_empty2", forwarding, 0);
        drive(t);
        idle(); at_neg(); chk("t3_tail_fwd", forwarding_tail, 1);
        tick(); at_neg(); chk("t3_req_drop", request, 0);

        // Fill to Depth with outputs stalled, then drain with the 5th flit held upstream
        out_ready = '0; grant = '0;
        h  = mk(1, 0, 3'd0, 3'd2, 20'h00041);
        b  = mk(0, 0, 3'd0, 3'd0, 20'h00042);
        b2 = mk(1, 0, 3'd6, 3'd6, 20'h00043);
        t  = mk(0, 1, 3'd0, 3'd0, 20'h00044);
        x  = mk(1, 1, 3'd0, 3'd2, 20'h00045);
        expect_fwd(h,  5'b00100, 1, 0);
        expect_fwd(b,  5'b00100, 0, 0);
        expect_fwd(b2, 5'b00100, 0, 0);
        expect_fwd(t,  5'b00100, 0, 1);
        expect_fwd(x,  5'b00100, 1, 1);
        drive(h); drive(b); drive(b2); drive(t);
        drive(x); at_neg(); chk("t4_full", stop_out, 1);
        tick(); at_neg();
        chk("t4_full_hold", stop_out, 1); chk("t4_stalled", forwarding, 0);
        tick(); out_ready = 5'b11111; grant = 5'b00100; at_neg();
        chk("t4_full_during_pop", stop_out, 1); chk("t4_pop", forwarding, 1);
        tick(); at_neg(); chk("t4_stop_release", stop_out, 0);
        idle(); idle(); idle(); idle(); at_neg();
        chk("t4_drained_req", request, 0); chk("t4_drained_stop", stop_out, 0);

        // Stray body flit while IDLE is dropped
        grant = '0;
        b = mk(0, 0, 3'd3, 3'd3, 20'h00051);
        drop_q.push_back(b);
        drive(b);
        idle(); at_neg();
        chk("t5_drop", drop_pulse, 1); chk("t5_drop_req", request, 0);
        tick(); at_neg();
        chk("t5_drop_once", drop_pulse, 0); chk("t5_empty_req", request, 0);
        chk("t5_empty_fwd", forwarding, 0);

        // Reset in the middle of a packet
        out_ready = '0; grant = '0;
        h  = mk(1, 0, 3'd2, 3'd0, 20'h00061);
        b  = mk(0, 0, 3'd0, 3'd0, 20'h00062);
        b2 = mk(0, 0, 3'd0, 3'd0, 20'h00063);
        expect_fwd(h, 5'b00001, 1, 0);
        expect_fwd(b, 5'b00001, 0, 0);
        drive(h); drive(b); drive(b2);
        tick(); data_void_in = 1'b1; grant = 5'b00001; out_ready = 5'b00001; at_neg();
        tick(); grant = '0; at_neg(); chk("t6_pkt_req", request, 5'b00001);
        tick(); rst = 1'b1; out_ready = '0; at_neg();
        tick(); rst = 1'b0; at_neg();
        chk("t6_rst_req", request, 0); chk("t6_rst_stop", stop_out, 0);
        chk("t6_rst_fwd", forwarding, 0); chk("t6_rst_data", data_out, 0);
        grant = 5'b10000; out_ready = 5'b11111;
        x = mk(1, 1, 3'd2, 3'd2, 20'h00064);
        expect_fwd(x, 5'b10000, 1, 1);
        drive(x);
        idle(); at_neg(); chk("t6_local_req", request, 5'b10000);
        tick(); at_neg(); chk("t6_local_done", request, 0);

        tick(); tick();
        chk("fwd_queue_drained", exp_q.size(), 0);
        chk("drop_queue_drained", drop_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
